adc_conv_arbiter: RTL and testbench

Shares the single ADC conversion/readout path between two requesters: port 0, the streaming acquisition trigger, and port 1, the single-shot or calibration reader. The block grants one requester at a time and drives `cnv` for a fixed high time. It then waits for the ADC `busy` to fall, starts the SPI readout with a `trigger` pulse, and reports completion or timeout back to the owning requester. It sits between the trigger logic and the ADC pins/SPI reader.

---
 rtl/adc_conv_arbiter_if.sv | 26 ++
 rtl/adc_conv_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_adc_conv_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_conv_arbiter_if.sv
// Handshake bundle between the requesters / ADC pins / SPI reader and the
// conversion arbiter. The slave modport is the arbiter side.
interface adc_conv_arbiter_if;
  logic [1:0] req;
  logic       cfg_rr;
  logic [1:0] ack;
  logic [1:0] err;
  logic       active;
  logic       owner;
  logic       cnv;
  logic       busy;
  logic       trigger;
  logic       read_done;
  logic       timeout_clr;
  logic       timeout;

  modport slave (
    input  req, cfg_rr, busy, read_done, timeout_clr,
    output ack, err, active, owner, cnv, trigger, timeout
  );

  modport master (
    output req, cfg_rr, busy, read_done, timeout_clr,
    input  ack, err, active, owner, cnv, trigger, timeout
  );
endinterface

// File: rtl/adc_conv_arbiter.sv
// Two-port arbiter for the shared ADC conversion/readout path: grants one
// requester, pulses cnv, waits for busy to fall, triggers SPI readout, acks or times out.
module adc_conv_arbiter #(
  parameter int CNV_HIGH_CYCLES = 3,
  parameter int BUSY_TIMEOUT    = 512
) (
  input  logic              clk,
  input  logic              resetn,
  adc_conv_arbiter_if.slave bus
);

  generate
    if (CNV_HIGH_CYCLES < 3) begin : g_bad_cnv
      $error("CNV_HIGH_CYCLES must be 3 or more");
    end
    if (BUSY_TIMEOUT < 1) begin : g_bad_tmo
      $error("BUSY_TIMEOUT must be 1 or more");
    end
  endgenerate

  localparam int CNV_W = $clog2(CNV_HIGH_CYCLES);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNV_W-1:0] CNV_LAST  = CNV_W'(CNV_HIGH_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(BUSY_TIMEOUT);

  // DONE is the ack/err cycle; it keeps a still-held req from being regranted.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CNV,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNV_W-1:0] cnv_cnt_q, cnv_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [TMO_W-1:0] tmo_next;
  logic             busy_meta_q, busy_s_q;
  logic             cnv_q, cnv_d;
  logic             trigger_q, trigger_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       err_q, err_d;
  logic             active_q, active_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             timeout_q, timeout_d;
  logic             win;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      busy_meta_q <= bus.busy;
      busy_s_q    <= busy_meta_q;
    end
  end

  // On a tie, round-robin favours the port that did not win last time.
  always_comb begin
    win = 1'b0;
    if (bus.req == 2'b11) begin
      win = bus.cfg_rr ? ~last_q : 1'b0;
    end else begin
      win = ~bus.req[0];
    end
  end

  assign tmo_next = tmo_cnt_q + TMO_W'(1);

  always_comb begin
    state_d   = state_q;
    cnv_cnt_d = cnv_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    cnv_d     = cnv_q;
    trigger_d = 1'b0;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    active_d  = active_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timeout_d = timeout_q & ~bus.timeout_clr;

    case (state_q)
      S_IDLE: begin
        if ((|bus.req) && !busy_s_q) begin
          state_d   = S_CNV;
          cnv_d     = 1'b1;
          active_d  = 1'b1;
          owner_d   = win;
          last_d    = win;
          cnv_cnt_d = '0;
        end
      end
      S_CNV: begin
        if (cnv_cnt_q == CNV_LAST) begin
          state_d   = S_WAIT;
          cnv_d     = 1'b0;
          tmo_cnt_d = '0;
        end else begin
          cnv_cnt_d = cnv_cnt_q + CNV_W'(1);
        end
      end
      S_WAIT: begin
        tmo_cnt_d = tmo_next;
        if (tmo_next == TMO_LIMIT) begin
          err_d     = owner_q ? 2'b10 : 2'b01;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (!busy_s_q) begin
          trigger_d = 1'b1;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        tmo_cnt_d = tmo_next;
        // A capture landing on the timeout edge still completes normally.
        if (bus.read_done) begin
          ack_d   = owner_q ? 2'b10 : 2'b01;
          state_d = S_DONE;
        end else if (tmo_next == TMO_LIMIT) begin
          err_d     = owner_q ? 2'b10 : 2'b01;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        cnv_d    = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnv_cnt_q <= '0;
      tmo_cnt_q <= '0;
      cnv_q     <= 1'b0;
      trigger_q <= 1'b0;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      active_q  <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnv_cnt_q <= cnv_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      cnv_q     <= cnv_d;
      trigger_q <= trigger_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      active_q  <= active_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign bus.ack[gi] = ack_q[gi];
      assign bus.err[gi] = err_q[gi];
    end
  endgenerate

  assign bus.cnv     = cnv_q;
  assign bus.trigger = trigger_q;
  assign bus.active  = active_q;
  assign bus.owner   = owner_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_adc_conv_arbiter.sv
// Bench for adc_conv_arbiter: ADC/SPI behavioural models around a default
// instance, plus a short-timeout instance for abort and coincidence cases.
`timescale 1ns/1ps
module tb_adc_conv_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int cnv_busy_viol = 0;
  int prev_owner = -1;

  logic adc_busy = 1'b0;
  logic spi_rd = 1'b0;
  logic man_rd = 1'b0;
  logic t_rd = 1'b0;

  adc_conv_arbiter_if if_a ();
  adc_conv_arbiter_if if_t ();

  assign if_a.busy      = adc_busy;
  assign if_a.read_done = spi_rd | man_rd;
  assign if_t.busy      = 1'b0;
  assign if_t.read_done = t_rd;

  adc_conv_arbiter dut_a (.clk(clk), .resetn(resetn), .bus(if_a));
  adc_conv_arbiter #(.CNV_HIGH_CYCLES(3), .BUSY_TIMEOUT(16)) dut_t (.clk(clk), .resetn(resetn), .bus(if_t));

  always @(posedge clk) cyc <= cyc + 1;

  // ADC: busy rises shortly after cnv and stays high for 282 ns.
  always @(posedge if_a.cnv) begin
    if (adc_busy) cnv_busy_viol++;
    #5 adc_busy = 1'b1;
    #282 adc_busy = 1'b0;
  end

  always @(negedge adc_busy) fall_cyc = cyc;

  // SPI reader: read_done 10 cycles after trigger.
  always begin
    @(negedge clk);
    if (if_a.trigger) begin
      repeat (10) @(negedge clk);
      spi_rd = 1'b1;
      @(negedge clk);
      spi_rd = 1'b0;
    end
  end

  function automatic int exp_win(input logic [1:0] r, input logic rr, input int prev);
    if (r == 2'b11) return rr ? ((prev == 0) ? 1 : 0) : 0;
    return r[0] ? 0 : 1;
  endfunction

  task automatic watch_a(output int own, output int cnv_len, output int trig_n, output int trig_lat,
                         output logic [1:0] ack_v, output logic [1:0] err_v, output int pulse_len,
                         output logic act_after, output bit hung);
    int n;
    hung = 1'b0; own = -1; cnv_len = 0; trig_n = 0; trig_lat = -1;
    ack_v = 2'b00; err_v = 2'b00; pulse_len = 0; act_after = 1'b1; n = 0;
    @(negedge clk);
    while (!if_a.active && n < 3000) begin @(negedge clk); n++; end
    if (!if_a.active) begin hung = 1'b1; return; end
    own = int'(if_a.owner);
    while (if_a.cnv && n < 3000) begin cnv_len++; @(negedge clk); n++; end
    while (!((|if_a.ack) || (|if_a.err)) && n < 3000) begin
      if (if_a.trigger) begin trig_n++; trig_lat = cyc - fall_cyc; end
      @(negedge clk); n++;
    end
    if (!((|if_a.ack) || (|if_a.err))) begin hung = 1'b1; return; end
    ack_v = if_a.ack; err_v = if_a.err;
    while (((|if_a.ack) || (|if_a.err)) && n < 3000) begin pulse_len++; @(negedge clk); n++; end
    act_after = if_a.active;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({if_a.cnv, if_a.trigger, if_a.ack, if_a.err, if_a.active, if_a.owner, if_a.timeout} !== 9'd0) begin
      bad++; $display("FAIL reset_outputs_a got=%b exp=0", {if_a.cnv, if_a.trigger, if_a.ack, if_a.err, if_a.active, if_a.owner, if_a.timeout}); end
    total++; if ({if_t.cnv, if_t.trigger, if_t.ack, if_t.err, if_t.active, if_t.owner, if_t.timeout} !== 9'd0) begin
      bad++; $display("FAIL reset_outputs_t got=%b exp=0", {if_t.cnv, if_t.trigger, if_t.ack, if_t.err, if_t.active, if_t.owner, if_t.timeout}); end
    resetn = 1'b1;
    prev_owner = -1;
    repeat (2) @(negedge clk);
    total++; if (if_a.active !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b exp=0", if_a.active); end
  endtask

  task automatic test_single();
    int own, cl, tn, tl, pl; logic [1:0] av, ev; logic aa; bit hung;
    if_a.cfg_rr = 1'b0; if_a.req = 2'b01;
    watch_a(own, cl, tn, tl, av, ev, pl, aa, hung);
    if_a.req = 2'b00;
    $display("txn single owner=%0d cnv_len=%0d trig=%0d lat=%0d ack=%b err=%b", own, cl, tn, tl, av, ev);
    total++; if (hung) begin bad++; $display("FAIL single_hang got=1 exp=0"); end
    total++; if (own !== exp_win(2'b01, 1'b0, prev_owner)) begin bad++; $display("FAIL single_owner got=%0d exp=0", own); end
    prev_owner = 0;
    total++; if (cl !== 3) begin bad++; $display("FAIL single_cnv_len got=%0d exp=3", cl); end
    total++; if (tn !== 1) begin bad++; $display("FAIL single_trig_count got=%0d exp=1", tn); end
    total++; if (tl !== 3) begin bad++; $display("FAIL single_trig_latency got=%0d exp=3", tl); end
    total++; if (av !== 2'b01) begin bad++; $display("FAIL single_ack got=%b exp=01", av); end
    total++; if (ev !== 2'b00) begin bad++; $display("FAIL single_err got=%b exp=00", ev); end
    total++; if (pl !== 1) begin bad++; $display("FAIL single_ack_width got=%0d exp=1", pl); end
    total++; if (aa !== 1'b0) begin bad++; $display("FAIL single_active_after got=%b exp=0", aa); end
  endtask

  task automatic test_arb(input logic rr);
    int own, cl, tn, tl, pl, ew; logic [1:0] av, ev; logic aa; bit hung;
    if_a.cfg_rr = rr; if_a.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      watch_a(own, cl, tn, tl, av, ev, pl, aa, hung);
      ew = exp_win(2'b11, rr, prev_owner);
      prev_owner = ew;
      $display("txn arb rr=%0d idx=%0d owner=%0d exp=%0d ack=%b", rr, i, own, ew, av);
      total++; if (hung || own !== ew) begin bad++; $display("FAIL arb_owner rr=%0d idx=%0d got=%0d exp=%0d", rr, i, own, ew); end
      total++; if (av !== ((ew == 1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL arb_ack rr=%0d idx=%0d got=%b exp_owner=%0d", rr, i, av, ew); end
    end
    if_a.req = 2'b00;
    total++; if (cnv_busy_viol !== 0) begin bad++; $display("FAIL cnv_while_busy got=%0d exp=0", cnv_busy_viol); end
  endtask

  task automatic test_timeout();
    int n, k; logic [1:0] rv, eb;
    if_t.cfg_rr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rv = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      eb = rv;
      if_t.req = rv;
      n = 0;
      @(negedge clk);
      while (!if_t.active && n < 200) begin @(negedge clk); n++; end
      while (if_t.cnv && n < 200) begin @(negedge clk); n++; end
      k = 0;
      while (!((|if_t.ack) || (|if_t.err)) && k < 100) begin
        if_t.timeout_clr = (c == 1 && k == 15);
        t_rd = (c == 2 && k == 15);
        @(negedge clk); k++;
      end
      if_t.timeout_clr = 1'b0; t_rd = 1'b0;
      $display("txn timeout case=%0d req=%b k=%0d ack=%b err=%b timeout=%b", c, rv, k, if_t.ack, if_t.err, if_t.timeout);
      total++; if (k !== 16) begin bad++; $display("FAIL tmo_cycles case=%0d got=%0d exp=16", c, k); end
      total++; if (if_t.err !== ((c == 2) ? 2'b00 : eb)) begin bad++; $display("FAIL tmo_err case=%0d got=%b exp=%b", c, if_t.err, (c == 2) ? 2'b00 : eb); end
      total++; if (if_t.ack !== ((c == 2) ? eb : 2'b00)) begin bad++; $display("FAIL tmo_ack case=%0d got=%b exp=%b", c, if_t.ack, (c == 2) ? eb : 2'b00); end
      total++; if (if_t.timeout !== ((c == 2) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL tmo_flag case=%0d got=%b exp=%b", c, if_t.timeout, (c == 2) ? 1'b0 : 1'b1); end
      if_t.req = 2'b00;
      n = 0;
      for (int j = 0; j < 5; j++) begin @(negedge clk); if (if_t.timeout !== ((c == 2) ? 1'b0 : 1'b1)) n++; end
      total++; if (n !== 0) begin bad++; $display("FAIL tmo_sticky case=%0d got=%0d_bad_cycles exp=0", c, n); end
      if_t.timeout_clr = 1'b1;
      @(negedge clk);
      if_t.timeout_clr = 1'b0;
      total++; if (if_t.timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear case=%0d got=%b exp=0", c, if_t.timeout); end
    end
  endtask

  task automatic test_reset_mid();
    int own, cl, tn, tl, pl, n; logic [1:0] av, ev; logic aa; bit hung;
    if_a.cfg_rr = 1'b0; if_a.req = 2'b01;
    n = 0;
    @(negedge clk);
    while (!if_a.cnv && n < 3000) begin @(negedge clk); n++; end
    total++; if (!if_a.cnv) begin bad++; $display("FAIL rmid_cnv_seen got=0 exp=1"); end
    #3 resetn = 1'b0;
    #1;
    total++; if (if_a.cnv !== 1'b0) begin bad++; $display("FAIL rmid_cnv_async got=%b exp=0", if_a.cnv); end
    if_a.req = 2'b00;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    prev_owner = -1;
    n = 0;
    for (int j = 0; j < 30; j++) begin @(negedge clk); if ((|if_a.ack) || (|if_a.err) || if_a.active) n++; end
    $display("txn reset_mid spurious_cycles=%0d", n);
    total++; if (n !== 0) begin bad++; $display("FAIL rmid_spurious got=%0d exp=0", n); end
    if_a.req = 2'b10;
    watch_a(own, cl, tn, tl, av, ev, pl, aa, hung);
    if_a.req = 2'b00;
    prev_owner = 1;
    $display("txn after_reset owner=%0d ack=%b", own, av);
    total++; if (hung || own !== exp_win(2'b10, 1'b0, -1)) begin bad++; $display("FAIL rmid_regrant_owner got=%0d exp=1", own); end
    total++; if (av !== 2'b10) begin bad++; $display("FAIL rmid_regrant_ack got=%b exp=10", av); end
  endtask

  task automatic test_withdraw_ignored();
    int n; logic [1:0] av;
    if_a.cfg_rr = 1'b0; if_a.req = 2'b01;
    n = 0;
    @(negedge clk);
    while (!if_a.trigger && n < 3000) begin @(negedge clk); n++; end
    if_a.req = 2'b11;
    repeat (2) @(negedge clk);
    if_a.req = 2'b01;
    n = 0;
    while (!((|if_a.ack) || (|if_a.err)) && n < 3000) begin @(negedge clk); n++; end
    av = if_a.ack;
    @(negedge clk);
    if_a.req = 2'b00;
    prev_owner = 0;
    total++; if (av !== 2'b01) begin bad++; $display("FAIL wd_ack got=%b exp=01", av); end
    n = 0;
    for (int j = 0; j < 30; j++) begin @(negedge clk); if (if_a.active) n++; end
    $display("txn withdraw ack=%b later_active_cycles=%0d", av, n);
    total++; if (n !== 0) begin bad++; $display("FAIL wd_no_grant got=%0d exp=0", n); end
    man_rd = 1'b1;
    @(negedge clk);
    man_rd = 1'b0;
    n = 0;
    for (int j = 0; j < 5; j++) begin @(negedge clk); if ((|if_a.ack) || (|if_a.err) || if_a.trigger) n++; end
    $display("txn idle_read_done spurious_cycles=%0d", n);
    total++; if (n !== 0) begin bad++; $display("FAIL idle_read_done got=%0d exp=0", n); end
  endtask

  initial begin
    if_a.req = 2'b00; if_a.cfg_rr = 1'b0; if_a.timeout_clr = 1'b0;
    if_t.req = 2'b00; if_t.cfg_rr = 1'b0; if_t.timeout_clr = 1'b0;
    test_reset();
    test_single();
    test_arb(1'b0);
    test_arb(1'b1);
    test_timeout();
    test_reset_mid();
    test_withdraw_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
